// File: rtl/dma_uart_pkg.sv
// Shared definitions for the 7-bit-address UART DMA protocol, used by both
// the initiator and the responder.
package dma_uart_pkg;
    localparam int CMD_WE_BIT    = 7;
    localparam int CMD_ADDR_MSB  = 6;
    localparam int DMA_ADDR_BITS = 7;
    localparam int DMA_WORD_BITS = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MSB,
        ST_WR_LSB,
        ST_RD_LOAD,
        ST_RD_TX_MSB,
        ST_RD_GAP_MSB,
        ST_RD_WAIT_MSB,
        ST_RD_TX_LSB,
        ST_RD_GAP_LSB,
        ST_RD_WAIT_LSB
    } rsp_state_e;

    function automatic logic cmd_is_write(input logic [7:0] cmd);
        return cmd[CMD_WE_BIT];
    endfunction
endpackage

// File: rtl/dma_uart_responder_if.sv
// Byte handshake between a uart_rx/uart_tx pair and the DMA responder.
interface dma_uart_responder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output rx_valid, rx_data, tx_busy, input tx_en, tx_data);
    modport slave  (input rx_valid, rx_data, tx_busy, output tx_en, tx_data);
endinterface

// File: rtl/dma_word_mem.sv
// Simple dual-port word store: port A read/write for the FSM, port B
// read-only for debug. Both reads are registered and read-first.
module dma_word_mem #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_rdata_o
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    end

    // Contents are never reset; only the read registers are.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_rdata_o <= '0;
            b_rdata_o <= '0;
        end else begin
            a_rdata_o <= mem_q[a_addr_i];
            b_rdata_o <= mem_q[b_addr_i];
        end
    end
endmodule

// File: rtl/dma_uart_responder.sv
// Memory-side end of the UART DMA protocol: decodes command bytes, commits
// fp16 writes to a local word store and streams read data back MSB first.
module dma_uart_responder
    import dma_uart_pkg::*;
#(
    parameter int ADDR_BITS      = DMA_ADDR_BITS,
    parameter int DATA_BITS      = DMA_WORD_BITS,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 resetn,
    dma_uart_responder_if.slave  uart,
    output logic                 busy,
    output logic                 wr_strobe,
    output logic                 err_timeout,
    output logic                 err_overrun,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_BITS-1:0] dbg_rdata
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    rsp_state_e           state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [7:0]           msb_q;
    logic [7:0]           lsb_q;
    logic [TW-1:0]        timer_q;
    logic                 tx_en_q, busy_q, wr_strobe_q, err_timeout_q, err_overrun_q;
    logic [7:0]           tx_data_q;

    logic                 mem_we;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 rd_phase;
    logic                 expired;

    // The write lands on the same edge that accepts the LSB byte.
    assign mem_we   = (state_q == ST_WR_LSB) && uart.rx_valid;
    assign rd_phase = state_q inside {ST_RD_LOAD, ST_RD_TX_MSB, ST_RD_GAP_MSB, ST_RD_WAIT_MSB,
                                      ST_RD_TX_LSB, ST_RD_GAP_LSB, ST_RD_WAIT_LSB};
    assign expired  = timer_q == TW'(TIMEOUT_CYCLES - 1);

    dma_word_mem #(.AW(ADDR_BITS), .DW(DATA_BITS)) u_mem (
        .clk       (clk),
        .resetn    (resetn),
        .a_we_i    (mem_we),
        .a_addr_i  (addr_q),
        .a_wdata_i ({msb_q, uart.rx_data}),
        .a_rdata_o (mem_rdata),
        .b_addr_i  (dbg_addr),
        .b_rdata_o (dbg_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            msb_q         <= '0;
            lsb_q         <= '0;
            timer_q       <= '0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            wr_strobe_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            tx_en_q       <= 1'b0;
            wr_strobe_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= uart.rx_valid && rd_phase;
            case (state_q)
                ST_IDLE: if (uart.rx_valid) begin
                    addr_q  <= ADDR_BITS'(uart.rx_data[CMD_ADDR_MSB:0]);
                    busy_q  <= 1'b1;
                    timer_q <= '0;
                    state_q <= cmd_is_write(uart.rx_data) ? ST_WR_MSB : ST_RD_LOAD;
                end
                ST_WR_MSB, ST_WR_LSB: begin
                    // An arriving byte wins over a timer expiring on the same cycle.
                    if (uart.rx_valid) begin
                        timer_q <= '0;
                        if (state_q == ST_WR_MSB) begin
                            msb_q   <= uart.rx_data;
                            state_q <= ST_WR_LSB;
                        end else begin
                            wr_strobe_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end else if (expired) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RD_LOAD:    state_q <= ST_RD_TX_MSB;
                ST_RD_TX_MSB: begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= mem_rdata[DATA_BITS-1 -: 8];
                    lsb_q     <= mem_rdata[7:0];
                    state_q   <= ST_RD_GAP_MSB;
                end
                ST_RD_GAP_MSB:  state_q <= ST_RD_WAIT_MSB;
                ST_RD_WAIT_MSB: if (!uart.tx_busy) state_q <= ST_RD_TX_LSB;
                ST_RD_TX_LSB: begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= lsb_q;
                    state_q   <= ST_RD_GAP_LSB;
                end
                ST_RD_GAP_LSB:  state_q <= ST_RD_WAIT_LSB;
                ST_RD_WAIT_LSB: if (!uart.tx_busy) begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart.tx_en   = tx_en_q;
    assign uart.tx_data = tx_data_q;
    assign busy         = busy_q;
    assign wr_strobe    = wr_strobe_q;
    assign err_timeout  = err_timeout_q;
    assign err_overrun  = err_overrun_q;
endmodule
